// File: rtl/vga_out_stage_if.sv
// Pixel bus between the timing generator / pixel core and the VGA output stage,
// plus the PMOD outputs and per-frame signature results.
interface vga_out_stage_if #(
  parameter int unsigned FRAME_CNT_W = 16
) ();

  // Upstream pixel and timing signals
  logic [9:0]             xOrd;
  logic [9:0]             yOrd;
  logic                   visible;
  logic                   hSyncIn;
  logic                   vSyncIn;
  logic [7:0]             red;
  logic [7:0]             green;
  logic [7:0]             blue;

  // RGB222 and realigned syncs towards the PMOD
  logic [1:0]             rOut;
  logic [1:0]             gOut;
  logic [1:0]             bOut;
  logic                   hSyncOut;
  logic                   vSyncOut;
  logic                   visibleOut;

  // Frame signature results
  logic [15:0]            sigOut;
  logic [18:0]            pixCount;
  logic [FRAME_CNT_W-1:0] frameCount;
  logic                   sigValid;

  // Pixel source side: drives the pixel bus, observes the results
  modport master (
    output xOrd, yOrd, visible, hSyncIn, vSyncIn, red, green, blue,
    input  rOut, gOut, bOut, hSyncOut, vSyncOut, visibleOut,
    input  sigOut, pixCount, frameCount, sigValid
  );

  // Output stage side
  modport slave (
    input  xOrd, yOrd, visible, hSyncIn, vSyncIn, red, green, blue,
    output rOut, gOut, bOut, hSyncOut, vSyncOut, visibleOut,
    output sigOut, pixCount, frameCount, sigValid
  );

endinterface

// File: rtl/vga_out_stage.sv
// VGA output stage: RGB888 -> RGB222 with 4x4 Bayer dither (or plain rounding),
// two-stage pipeline keeping syncs aligned with pixels, and a per-frame
// CRC-16-CCITT signature / pixel count / frame count computed on the output side.
module vga_out_stage #(
  parameter bit          DITHER_EN   = 1'b1,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_out_stage_if.slave bus
);

  // 4x4 ordered-dither threshold, row = line[1:0], column = pixel[1:0]
  function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] m;
    unique case ({row, col})
      4'h0: m = 4'd0;
      4'h1: m = 4'd8;
      4'h2: m = 4'd2;
      4'h3: m = 4'd10;
      4'h4: m = 4'd12;
      4'h5: m = 4'd4;
      4'h6: m = 4'd14;
      4'h7: m = 4'd6;
      4'h8: m = 4'd3;
      4'h9: m = 4'd11;
      4'hA: m = 4'd1;
      4'hB: m = 4'd9;
      4'hC: m = 4'd15;
      4'hD: m = 4'd7;
      4'hE: m = 4'd13;
      4'hF: m = 4'd5;
    endcase
    return m;
  endfunction

  // CRC-16-CCITT (0x1021), six data bits shifted in MSB first in one step
  function automatic logic [15:0] crc16_step6(input logic [15:0] crc, input logic [5:0] word);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 5; i >= 0; i--) begin
      fb = c[15] ^ word[i];
      c  = {c[14:0], 1'b0};
      if (fb) begin
        c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  // Channel scaling: c*3 + bias; the top two bits of the 10-bit sum are the RGB222 value.
  // Rounding uses a fixed bias of 128, dithering uses M*16 + 8.
  logic [3:0] thresh;
  logic [9:0] bias;
  logic [9:0] sum_r_d, sum_g_d, sum_b_d;

  // Stage 1 state
  logic [9:0] sum_r_q, sum_g_q, sum_b_q;
  logic       vis1_q, hs1_q, vs1_q;

  // Stage 2 state (drives the PMOD)
  logic [1:0] r_q, g_q, b_q;
  logic [1:0] r_d, g_d, b_d;
  logic       vis2_q, hs2_q, vs2_q;

  // Signature state
  logic [15:0]            crc_q, crc_upd;
  logic [18:0]            cnt_q, cnt_upd;
  logic                   vs_prev_q;
  logic                   frame_end;
  logic [15:0]            sig_q;
  logic [18:0]            pix_q;
  logic [FRAME_CNT_W-1:0] fc_q;
  logic                   sig_valid_q;

  // Dither threshold and the three channel sums for the incoming pixel
  always_comb begin
    thresh = bayer(bus.yOrd[1:0], bus.xOrd[1:0]);
    if (DITHER_EN) begin
      bias = ({6'd0, thresh} << 4) + 10'd8;
    end else begin
      bias = 10'd128;
    end
    sum_r_d = ({2'b00, bus.red}   << 1) + {2'b00, bus.red}   + bias;
    sum_g_d = ({2'b00, bus.green} << 1) + {2'b00, bus.green} + bias;
    sum_b_d = ({2'b00, bus.blue}  << 1) + {2'b00, bus.blue}  + bias;
  end

  // Stage 1: register sums, visible and syncs (syncs idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r_q <= '0;
      sum_g_q <= '0;
      sum_b_q <= '0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
    end else begin
      sum_r_q <= sum_r_d;
      sum_g_q <= sum_g_d;
      sum_b_q <= sum_b_d;
      vis1_q  <= bus.visible;
      hs1_q   <= bus.hSyncIn;
      vs1_q   <= bus.vSyncIn;
    end
  end

  // Quantise and blank outside the active area
  always_comb begin
    r_d = vis1_q ? sum_r_q[9:8] : 2'b00;
    g_d = vis1_q ? sum_g_q[9:8] : 2'b00;
    b_d = vis1_q ? sum_b_q[9:8] : 2'b00;
  end

  // Stage 2: registered RGB222, syncs and visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= 2'b00;
      g_q    <= 2'b00;
      b_q    <= 2'b00;
      vis2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      vis2_q <= vis1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  // Running CRC / count including the pixel currently on the outputs, and frame-end detect.
  // Folding the current pixel in before latching covers a pixel that coincides with frame end.
  always_comb begin
    crc_upd   = vis2_q ? crc16_step6(crc_q, {r_q, g_q, b_q}) : crc_q;
    cnt_upd   = cnt_q + {18'd0, vis2_q};
    frame_end = vs_prev_q & ~vs2_q;
  end

  // Signature accumulation and per-frame latch on the falling edge of vSyncOut
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q       <= 16'hFFFF;
      cnt_q       <= '0;
      vs_prev_q   <= 1'b1;
      sig_q       <= '0;
      pix_q       <= '0;
      fc_q        <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      vs_prev_q <= vs2_q;
      if (frame_end) begin
        sig_q       <= crc_upd;
        pix_q       <= cnt_upd;
        fc_q        <= fc_q + FRAME_CNT_W'(1);
        sig_valid_q <= 1'b1;
        crc_q       <= 16'hFFFF;
        cnt_q       <= '0;
      end else begin
        sig_valid_q <= 1'b0;
        crc_q       <= crc_upd;
        cnt_q       <= cnt_upd;
      end
    end
  end

  assign bus.rOut       = r_q;
  assign bus.gOut       = g_q;
  assign bus.bOut       = b_q;
  assign bus.hSyncOut   = hs2_q;
  assign bus.vSyncOut   = vs2_q;
  assign bus.visibleOut = vis2_q;
  assign bus.sigOut     = sig_q;
  assign bus.pixCount   = pix_q;
  assign bus.frameCount = fc_q;
  assign bus.sigValid   = sig_valid_q;

  // Only the low coordinate bits and the top sum bits carry information here
  logic unused_bits;
  assign unused_bits = ^{bus.xOrd[9:2], bus.yOrd[9:2], sum_r_q[7:0], sum_g_q[7:0], sum_b_q[7:0]};

endmodule

// File: tb/tb_vga_out_stage.sv
// Bench for vga_out_stage: hand-computed pixel vectors, then small synthetic frames
// (12x8 total, 8x4 visible) driven into three instances: dither, rounding, 2-bit frame counter.
module tb_vga_out_stage;

  localparam int HTOT = 12;
  localparam int HVIS = 8;
  localparam int VTOT = 8;
  localparam int VVIS = 4;

  typedef struct packed {
    logic [1:0] rd, gd, bd;  // dither instance
    logic [1:0] rr, gr, br;  // rounding instance
    logic       hs, vs, vis;
  } exp_t;

  typedef struct {
    logic [9:0] x, y;
    logic       vis, hs, vs;
    logic [7:0] r, g, b;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] in_x = '0, in_y = '0;
  logic       in_vis = 1'b0, in_hs = 1'b1, in_vs = 1'b1;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;

  vga_out_stage_if #(.FRAME_CNT_W(16)) if_d ();
  vga_out_stage_if #(.FRAME_CNT_W(16)) if_r ();
  vga_out_stage_if #(.FRAME_CNT_W(2))  if_w ();

  assign if_d.xOrd = in_x;   assign if_r.xOrd = in_x;   assign if_w.xOrd = in_x;
  assign if_d.yOrd = in_y;   assign if_r.yOrd = in_y;   assign if_w.yOrd = in_y;
  assign if_d.visible = in_vis; assign if_r.visible = in_vis; assign if_w.visible = in_vis;
  assign if_d.hSyncIn = in_hs;  assign if_r.hSyncIn = in_hs;  assign if_w.hSyncIn = in_hs;
  assign if_d.vSyncIn = in_vs;  assign if_r.vSyncIn = in_vs;  assign if_w.vSyncIn = in_vs;
  assign if_d.red = in_r;    assign if_r.red = in_r;    assign if_w.red = in_r;
  assign if_d.green = in_g;  assign if_r.green = in_g;  assign if_w.green = in_g;
  assign if_d.blue = in_b;   assign if_r.blue = in_b;   assign if_w.blue = in_b;

  vga_out_stage #(.DITHER_EN(1'b1), .FRAME_CNT_W(16)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
  vga_out_stage #(.DITHER_EN(1'b0), .FRAME_CNT_W(16)) dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));
  vga_out_stage #(.DITHER_EN(1'b1), .FRAME_CNT_W(2))  dut_w (.clk(clk), .rst_n(rst_n), .bus(if_w));

  int errors = 0;
  int checks = 0;

  int bayer_tb [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  // Expected outputs two cycles behind the stimulus
  exp_t p1, p2;
  localparam exp_t IDLE = '{rd: 2'd0, gd: 2'd0, bd: 2'd0, rr: 2'd0, gr: 2'd0, br: 2'd0,
                            hs: 1'b1, vs: 1'b1, vis: 1'b0};

  // Signature reference state
  logic [15:0] m_crc_d, m_crc_r, m_sig_d, m_sig_r;
  int          m_cnt, m_pix, m_fc;
  logic        m_prev_vs, sv_exp;
  logic [15:0] mlog [16];
  int          n_m = 0;

  // Observed sigValid pulses
  logic [15:0] sig_log [16];
  int          pix_log [16];
  int          fcw_log [16];
  int          nlog = 0;

  logic tally_en = 1'b0;
  int   hs_low, vs_low, n1, n2;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input int act, input int other);
    checks++;
    if (act == other) begin
      errors++;
      $display("FAIL %s: got %0d, required a value different from %0d", name, act, other);
    end
  endtask

  function automatic logic [1:0] dith(input int c, input int x, input int y);
    int s;
    s = c * 3 + bayer_tb[y % 4][x % 4] * 16 + 8;
    return 2'(s / 256);
  endfunction

  function automatic logic [1:0] rnd(input int c);
    return 2'((c * 3 + 128) / 256);
  endfunction

  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [5:0] w);
    logic [15:0] c;
    c = crc ^ {w, 10'd0};
    for (int i = 0; i < 6; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic exp_t model_px(input int x, input int y, input logic v, input logic h,
                                    input logic vs, input int r, input int g, input int b);
    exp_t e;
    e.rd = v ? dith(r, x, y) : 2'd0;
    e.gd = v ? dith(g, x, y) : 2'd0;
    e.bd = v ? dith(b, x, y) : 2'd0;
    e.rr = v ? rnd(r) : 2'd0;
    e.gr = v ? rnd(g) : 2'd0;
    e.br = v ? rnd(b) : 2'd0;
    e.hs = h;
    e.vs = vs;
    e.vis = v;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [9:0] x, input logic [9:0] y, input logic v,
                               input logic h, input logic vs, input logic [7:0] r,
                               input logic [7:0] g, input logic [7:0] b, input logic [1:0] rd,
                               input logic [1:0] gd, input logic [1:0] bd, input logic [1:0] rr,
                               input logic [1:0] gr, input logic [1:0] br);
    vec_t t;
    t.x = x; t.y = y; t.vis = v; t.hs = h; t.vs = vs; t.r = r; t.g = g; t.b = b;
    t.e = '{rd: rd, gd: gd, bd: bd, rr: rr, gr: gr, br: br, hs: h, vs: vs, vis: v};
    return t;
  endfunction

  task automatic model_reset();
    p1 = IDLE; p2 = IDLE;
    m_crc_d = 16'hFFFF; m_crc_r = 16'hFFFF; m_cnt = 0; m_fc = 0;
    m_prev_vs = 1'b1; sv_exp = 1'b0;
  endtask

  // Compare outputs against the expectation from two steps ago, then advance the reference
  task automatic check_outputs();
    exp_t e;
    logic fe;
    e = p2;
    chk("rOut_d", if_d.rOut, e.rd);
    chk("gOut_d", if_d.gOut, e.gd);
    chk("bOut_d", if_d.bOut, e.bd);
    chk("rOut_r", if_r.rOut, e.rr);
    chk("gOut_r", if_r.gOut, e.gr);
    chk("bOut_r", if_r.bOut, e.br);
    chk("hSyncOut", if_d.hSyncOut, e.hs);
    chk("vSyncOut", if_d.vSyncOut, e.vs);
    chk("visibleOut", if_d.visibleOut, e.vis);
    chk("sigValid_d", if_d.sigValid, sv_exp);
    chk("sigValid_r", if_r.sigValid, sv_exp);
    chk("sigValid_w", if_w.sigValid, sv_exp);
    if (sv_exp) begin
      chk("sigOut_d", if_d.sigOut, m_sig_d);
      chk("sigOut_r", if_r.sigOut, m_sig_r);
      chk("sigOut_w", if_w.sigOut, m_sig_d);
      chk("pixCount", if_d.pixCount, m_pix);
      chk("frameCount_d", if_d.frameCount, m_fc);
      chk("frameCount_w", if_w.frameCount, m_fc % 4);
    end
    if (if_d.sigValid && nlog < 16) begin
      sig_log[nlog] = if_d.sigOut;
      pix_log[nlog] = if_d.pixCount;
      fcw_log[nlog] = if_w.frameCount;
      nlog++;
    end
    if (tally_en) begin
      if (!if_d.hSyncOut) hs_low++;
      if (!if_d.vSyncOut) vs_low++;
      if (if_d.visibleOut) begin
        if (if_d.rOut == 2'd1) n1++;
        else if (if_d.rOut == 2'd2) n2++;
      end
    end
    fe = m_prev_vs & ~e.vs;
    m_prev_vs = e.vs;
    if (e.vis) begin
      m_crc_d = crc_ref(m_crc_d, {e.rd, e.gd, e.bd});
      m_crc_r = crc_ref(m_crc_r, {e.rr, e.gr, e.br});
      m_cnt++;
    end
    if (fe) begin
      m_sig_d = m_crc_d; m_sig_r = m_crc_r; m_pix = m_cnt; m_fc++;
      if (n_m < 16) mlog[n_m] = m_crc_d;
      n_m++;
      m_crc_d = 16'hFFFF; m_crc_r = 16'hFFFF; m_cnt = 0;
    end
    sv_exp = fe;
  endtask

  task automatic step(input logic [9:0] xi, input logic [9:0] yi, input logic vi, input logic hi,
                      input logic vsi, input logic [7:0] ri, input logic [7:0] gi,
                      input logic [7:0] bi, input exp_t ei);
    @(negedge clk);
    check_outputs();
    in_x = xi; in_y = yi; in_vis = vi; in_hs = hi; in_vs = vsi;
    in_r = ri; in_g = gi; in_b = bi;
    p2 = p1;
    p1 = ei;
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_rOut"}, if_d.rOut, 0);
    chk({tag, "_gOut"}, if_d.gOut, 0);
    chk({tag, "_bOut"}, if_d.bOut, 0);
    chk({tag, "_hSyncOut"}, if_d.hSyncOut, 1);
    chk({tag, "_vSyncOut"}, if_d.vSyncOut, 1);
    chk({tag, "_visibleOut"}, if_d.visibleOut, 0);
    chk({tag, "_sigValid"}, if_d.sigValid, 0);
    chk({tag, "_frameCount_d"}, if_d.frameCount, 0);
    chk({tag, "_frameCount_w"}, if_w.frameCount, 0);
    chk({tag, "_sigOut"}, if_d.sigOut, 0);
    chk({tag, "_pixCount"}, if_d.pixCount, 0);
  endtask

  // Assert reset between edges, check it takes effect at once, hold, release between edges
  task automatic do_reset(input int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_values("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset_values("rst_hold");
    end
    in_vis = 1'b0; in_hs = 1'b1; in_vs = 1'b1; in_r = '0; in_g = '0; in_b = '0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // mode: 0 black, 1 white, 2 grey 128, 3 black with one white pixel at (3,2)
  task automatic run_frame(input int mode, input int rst_line);
    logic v, h, vs;
    int   c;
    for (int y = 0; y < VTOT; y++) begin
      for (int x = 0; x < HTOT; x++) begin
        if (y == rst_line && x == 0) do_reset(3);
        v  = (x < HVIS) && (y < VVIS);
        h  = !(x >= 9 && x <= 10);
        vs = !(y >= 5 && y <= 6);
        case (mode)
          1:       c = 255;
          2:       c = 128;
          3:       c = (x == 3 && y == 2) ? 255 : 0;
          default: c = 0;
        endcase
        step(10'(x), 10'(y), v, h, vs, 8'(c), 8'(c), 8'(c), model_px(x, y, v, h, vs, c, c, c));
      end
    end
  endtask

  int exp_fcw [6] = '{1, 2, 3, 0, 1, 1};

  initial begin
    //               x    y  v  hs vs  r    g    b    | dither  | rounding
    vecs[0]  = mkv(0,   0, 1, 1, 1, 128, 128, 128, 1, 1, 1, 2, 2, 2);
    vecs[1]  = mkv(1,   0, 1, 1, 1, 128, 128, 128, 2, 2, 2, 2, 2, 2);
    vecs[2]  = mkv(1,   1, 1, 0, 1, 128, 128, 128, 1, 1, 1, 2, 2, 2);
    vecs[3]  = mkv(0,   0, 1, 1, 1, 255, 0,   255, 3, 0, 3, 3, 0, 3);
    vecs[4]  = mkv(0,   3, 1, 1, 1, 42,  0,   200, 1, 0, 3, 0, 0, 2);
    vecs[5]  = mkv(0,   0, 1, 0, 1, 42,  200, 255, 0, 2, 3, 0, 2, 3);
    vecs[6]  = mkv(700, 0, 0, 0, 1, 255, 255, 255, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mkv(2,   1, 1, 1, 1, 100, 170, 1,   2, 2, 0, 1, 2, 0);
    vecs[8]  = mkv(3,   0, 1, 1, 1, 128, 128, 128, 2, 2, 2, 2, 2, 2);
    vecs[9]  = mkv(3,   2, 1, 1, 1, 160, 80,  250, 2, 1, 3, 2, 1, 3);
    vecs[10] = mkv(0,   0, 0, 1, 1, 0,   0,   0,   0, 0, 0, 0, 0, 0);

    // Reset held 5 cycles while a visible white pixel mid-line is presented
    in_x = 10'd300; in_y = 10'd100; in_vis = 1'b1; in_r = 8'd255; in_g = 8'd255; in_b = 8'd255;
    @(negedge clk);
    do_reset(5);

    foreach (vecs[i]) begin
      step(vecs[i].x, vecs[i].y, vecs[i].vis, vecs[i].hs, vecs[i].vs,
           vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].e);
    end
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, IDLE);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, IDLE);

    do_reset(2);
    run_frame(0, -1);
    run_frame(0, -1);
    run_frame(3, -1);

    hs_low = 0; vs_low = 0; n1 = 0; n2 = 0;
    tally_en = 1'b1;
    run_frame(1, -1);
    tally_en = 1'b0;
    chk("hsync_low_cycles", hs_low, 2 * VTOT);
    chk("vsync_low_cycles", vs_low, 2 * HTOT);

    hs_low = 0; vs_low = 0; n1 = 0; n2 = 0;
    tally_en = 1'b1;
    run_frame(2, -1);
    tally_en = 1'b0;
    chk("grey_ones", n1, 16);
    chk("grey_twos", n2, 16);

    run_frame(0, 2);
    for (int i = 0; i < 3; i++) begin
      step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, IDLE);
    end

    chk("sigValid_pulses", nlog, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("frameCount_w_seq%0d", i), fcw_log[i], exp_fcw[i]);
    chk("pixCount_frame1", pix_log[0], HVIS * VVIS);
    chk("pixCount_frame2", pix_log[1], HVIS * VVIS);
    chk("pixCount_partial", pix_log[5], HVIS * 2);
    chk("black_sig_repeat", sig_log[1], mlog[0]);
    chk_ne("sig_one_pixel_changed", sig_log[2], mlog[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
